video_sprite_line_engine: RTL and testbench

Parametrised scanline sprite engine for the 320x240 VGA video adaptor. It replaces per-pixel bounding-box sprite lookup with a per-line evaluation pass. During each line it scans a sprite attribute table and selects up to SLOTS sprites that intersect the next line. It fetches their bitmap rows into double-buffered slot registers and, on the displayed line, emits a prioritised sprite pixel that the tile/texture path muxes over the background.

---
 rtl/video_sprite_line_engine.sv | 187 ++++++++++++++++++
 tb/tb_video_sprite_line_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/video_sprite_line_engine.sv
// video_sprite_line_engine: per-line sprite evaluation into double-buffered slots, prioritised pixel out.
// Define VIDEO_SPRITE_COLLISION_EN to build the sprite-sprite collision flag.
module video_sprite_line_engine #(
  parameter int NUM_SPRITES = 16,
  parameter int SLOTS = 4,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  localparam int RB = $clog2(SPRITE_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  input  logic                line_start,
  input  logic [8:0]          next_y,
  input  logic [8:0]          pixel_x,
  input  logic                pixel_en,
  output logic [6+RB-1:0]     spr_raddr,
  input  logic [SPRITE_W-1:0] spr_rdata,
  output logic                pix_opaque,
  output logic [2:0]          pix_color,
  output logic                busy,
  output logic                overflow,
  output logic                collision
);
  localparam int WB = $clog2(SPRITE_W);
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam int FW = SLOTS > 1 ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FETCH} state_t;
  state_t state, state_nx;

  logic [31:0] attr [NUM_SPRITES];
  logic [8:0] ny;
  logic [IW-1:0] idx;
  logic [CW-1:0] hit_cnt;
  logic [FW-1:0] fs;
  logic ph;

  logic [8:0] sh_x [SLOTS];
  logic [2:0] sh_col [SLOTS];
  logic [5:0] sh_img [SLOTS];
  logic [RB-1:0] sh_dy [SLOTS];
  logic [SPRITE_W-1:0] sh_row [SLOTS];
  logic [SLOTS-1:0] sh_hf, sh_valid;

  logic [8:0] ac_x [SLOTS];
  logic [2:0] ac_col [SLOTS];
  logic [SPRITE_W-1:0] ac_row [SLOTS];
  logic [SLOTS-1:0] ac_hf, ac_valid;

  logic [31:0] cur;
  logic [8:0] dy;
  logic hit, full, last_idx, last_fs, clr, ovf_set;
  logic [5:0] wr_idx;
  logic unused;

  assign cur = attr[idx];
  assign dy = ny - cur[17:9];
  assign hit = state == SCAN && cur[31] && dy < 9'(SPRITE_H);
  assign full = hit_cnt == CW'(SLOTS);
  assign last_idx = idx == IW'(NUM_SPRITES - 1);
  assign last_fs = CW'(fs) + CW'(1) == hit_cnt;
  assign wr_idx = iomem_addr[7:2];
  assign clr = iomem_valid && wr_idx == 6'd63 && iomem_wstrb[0];
  assign ovf_set = hit && full;
  assign busy = state != IDLE;
  assign spr_raddr = state == FETCH ? {sh_img[fs], sh_dy[fs]} : '0;
  assign unused = ^{iomem_addr[31:8], iomem_addr[1:0], cur[30], cur[28:27]};

  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;

  // line_start restarts the pass from any state
  always_comb begin
    state_nx = line_start ? SCAN
      : state == SCAN && last_idx ? ((hit || hit_cnt != '0) ? FETCH : IDLE)
      : state == FETCH && ph && last_fs ? IDLE
      : state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) attr[i] <= '0;
    end else if (iomem_valid) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        if (wr_idx == 6'(i))
          for (int b = 0; b < 4; b++)
            if (iomem_wstrb[b]) attr[i][8*b +: 8] <= iomem_wdata[8*b +: 8];
    end
  end

  // shadow valid marks fetched slots, so a partial pass swaps in only complete rows
  always_ff @(posedge clk) begin
    if (reset) begin
      ny <= '0;
      idx <= '0;
      hit_cnt <= '0;
      fs <= '0;
      ph <= 1'b0;
      sh_valid <= '0;
      ac_valid <= '0;
    end else if (line_start) begin
      ny <= next_y;
      idx <= '0;
      hit_cnt <= '0;
      fs <= '0;
      ph <= 1'b0;
      sh_valid <= '0;
      ac_valid <= sh_valid;
      ac_x <= sh_x;
      ac_col <= sh_col;
      ac_hf <= sh_hf;
      ac_row <= sh_row;
    end else begin
      if (state == SCAN) idx <= last_idx ? '0 : idx + 1'b1;
      if (hit && !full) begin
        for (int s = 0; s < SLOTS; s++)
          if (CW'(s) == hit_cnt) begin
            sh_x[s] <= cur[8:0];
            sh_col[s] <= cur[26:24];
            sh_hf[s] <= cur[29];
            sh_img[s] <= cur[23:18];
            sh_dy[s] <= dy[RB-1:0];
          end
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (state == FETCH) begin
        ph <= ~ph;
        if (ph) begin
          sh_row[fs] <= spr_rdata;
          sh_valid[fs] <= 1'b1;
          fs <= fs + 1'b1;
        end
      end
    end
  end

  logic [SLOTS-1:0] op;
  logic [8:0] dx;
  logic [2:0] win_col;
  logic any;
`ifdef VIDEO_SPRITE_COLLISION_EN
  logic multi;
`endif

  always_comb begin
    op = '0;
    dx = '0;
    win_col = '0;
    any = 1'b0;
`ifdef VIDEO_SPRITE_COLLISION_EN
    multi = 1'b0;
`endif
    for (int s = 0; s < SLOTS; s++) begin
      dx = pixel_x - ac_x[s];
      op[s] = ac_valid[s] && dx < 9'(SPRITE_W) && ac_row[s][ac_hf[s] ? ~dx[WB-1:0] : dx[WB-1:0]];
`ifdef VIDEO_SPRITE_COLLISION_EN
      multi = multi | (any & op[s]);
`endif
      win_col = op[s] && !any ? ac_col[s] : win_col;
      any = any | op[s];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_opaque <= 1'b0;
      pix_color <= '0;
      overflow <= 1'b0;
    end else begin
      pix_opaque <= pixel_en && any;
      pix_color <= pixel_en ? win_col : 3'b0;
      overflow <= ovf_set ? 1'b1 : clr ? 1'b0 : overflow;
    end
  end

`ifdef VIDEO_SPRITE_COLLISION_EN
  always_ff @(posedge clk)
    collision <= reset ? 1'b0 : (pixel_en && multi) ? 1'b1 : clr ? 1'b0 : collision;
`else
  assign collision = 1'b0;
`endif
endmodule

// File: tb/tb_video_sprite_line_engine.sv
// tb_video_sprite_line_engine: directed vectors for the scanline sprite engine.
module tb_video_sprite_line_engine;
  logic clk = 0, reset = 1;
  logic iomem_valid = 0;
  logic [3:0] iomem_wstrb = 0;
  logic [31:0] iomem_addr = 0, iomem_wdata = 0;
  logic line_start = 0;
  logic [8:0] next_y = 0, pixel_x = 0;
  logic pixel_en = 0;
  logic [9:0] spr_raddr;
  logic [15:0] spr_rdata = 0;
  logic pix_opaque, busy, overflow, collision;
  logic [2:0] pix_color;

  int checks = 0, errors = 0;
  logic [15:0] mem [1024];

`ifdef VIDEO_SPRITE_COLLISION_EN
  localparam logic COL_EN = 1'b1;
`else
  localparam logic COL_EN = 1'b0;
`endif

  typedef struct {
    logic [8:0] px;
    logic en;
    logic op;
    logic [2:0] col;
  } vec_t;
  vec_t tv [17];

  video_sprite_line_engine dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .line_start(line_start),
    .next_y(next_y), .pixel_x(pixel_x), .pixel_en(pixel_en), .spr_raddr(spr_raddr),
    .spr_rdata(spr_rdata), .pix_opaque(pix_opaque), .pix_color(pix_color),
    .busy(busy), .overflow(overflow), .collision(collision)
  );

  always #5 clk = ~clk;
  always @(posedge clk) spr_rdata <= mem[spr_raddr];

  function automatic logic [31:0] mk(input logic [8:0] x, input logic [8:0] y, input logic [5:0] img,
                                     input logic [2:0] col, input logic hf);
    return {1'b1, 1'b0, hf, 2'b00, col, img, y, x};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int i, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    iomem_valid = 1; iomem_addr = 32'(i) << 2; iomem_wstrb = s; iomem_wdata = d;
    @(negedge clk);
    iomem_valid = 0;
  endtask

  task automatic pulse(input logic [8:0] y);
    @(negedge clk);
    line_start = 1; next_y = y;
    @(negedge clk);
    line_start = 0;
  endtask

  task automatic run_pass(input logic [8:0] y, input int exp, input string nm);
    int n;
    pulse(y);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp);
  endtask

  task automatic pix(input logic [8:0] px, input logic en, input logic op, input logic [2:0] col, input string nm);
    @(negedge clk);
    pixel_x = px; pixel_en = en;
    @(negedge clk);
    chk({nm, "_op"}, pix_opaque, op);
    chk({nm, "_col"}, pix_color, col);
    pixel_en = 0;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      pix(tv[i].px, tv[i].en, tv[i].op, tv[i].col, $sformatf("vec%0d", i));
  endtask

  task automatic set_v(input int i, input logic [8:0] px, input logic en, input logic op, input logic [2:0] col);
    tv[i] = '{px, en, op, col};
  endtask

  initial begin
    set_v(0, 10, 1, 1, 3'b001);  set_v(1, 11, 1, 0, 0);  set_v(2, 9, 1, 0, 0);
    set_v(3, 10, 0, 0, 0);
    set_v(4, 25, 1, 1, 3'b001);  set_v(5, 10, 1, 0, 0);  set_v(6, 26, 1, 0, 0);
    set_v(7, 0, 1, 1, 3'b001);   set_v(8, 60, 1, 1, 3'b100);
    set_v(9, 80, 1, 0, 0);       set_v(10, 75, 1, 1, 3'b100);
    set_v(11, 100, 1, 1, 3'b100); set_v(12, 115, 1, 1, 3'b100); set_v(13, 116, 1, 0, 0);
    set_v(14, 0, 1, 1, 3'b011);  set_v(15, 510, 1, 0, 0); set_v(16, 1, 1, 0, 0);
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    mem[16] = 16'h0001;
    mem[32] = 16'hFFFF;
    mem[48] = 16'h0001;
    mem[49] = 16'h0004;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_col", collision, 0);
    chk("rst_op", pix_opaque, 0);
    chk("rst_color", pix_color, 0);
    chk("rst_raddr", spr_raddr, 0);
    reset = 0;

    run_pass(0, 16, "empty_pass");
    chk("empty_ovf", overflow, 0);
    pix(10, 1, 0, 0, "empty_pix");

    wr(0, mk(10, 20, 1, 3'b001, 0), 4'hF);
    run_pass(20, 18, "one_hit_pass");
    run_pass(21, 18, "swap_pass");
    apply(0, 3);

    wr(0, mk(10, 20, 1, 3'b001, 1), 4'hF);
    run_pass(20, 18, "hflip_pass");
    run_pass(20, 18, "hflip_swap");
    apply(4, 6);

    for (int i = 0; i < 5; i++) wr(i, mk(9'(20 * i), 50, 2, 3'(i + 1), 0), 4'hF);
    run_pass(50, 24, "ovf_pass");
    chk("ovf_set", overflow, 1);
    run_pass(300, 16, "ovf_swap");
    chk("ovf_sticky", overflow, 1);
    apply(7, 10);
    chk("no_col", collision, 0);
    wr(63, 0, 4'b0010);
    chk("ovf_keep", overflow, 1);
    wr(63, 0, 4'b0001);
    chk("ovf_clr", overflow, 0);

    for (int i = 0; i < 5; i++) wr(i, 0, 4'hF);
    wr(2, mk(100, 60, 2, 3'b100, 0), 4'hF);
    wr(5, mk(100, 60, 2, 3'b010, 0), 4'hF);
    run_pass(60, 20, "col_pass");
    run_pass(300, 16, "col_swap");
    apply(11, 13);
    chk("col_flag", collision, COL_EN);
    wr(63, 0, 4'b0001);
    chk("col_clr", collision, 0);

    wr(2, 0, 4'hF);
    wr(5, 0, 4'hF);
    wr(7, mk(510, 511, 3, 3'b011, 0), 4'hF);
    run_pass(0, 18, "wrap_pass");
    run_pass(300, 16, "wrap_swap");
    apply(14, 16);

    run_pass(0, 18, "mid_prep");
    pulse(0);
    pix(0, 1, 1, 3'b011, "mid_full");
    run_pass(300, 16, "mid_restart");
    pix(0, 1, 0, 0, "mid_partial");

    pulse(0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    reset = 0;
    pix(0, 1, 0, 0, "rst_mid_pix");
    chk("rst_mid_busy2", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
